// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences the core reset, then watches the fetch
// stream for pass/fail addresses, a stuck pc, or a cycle budget running out.
module sim_run_ctrl #(
    parameter int unsigned     CW             = 32,
    parameter logic [CW-1:0]   RST_CYCLES     = CW'(10),
    parameter logic [CW-1:0]   TIMEOUT_CYCLES = CW'(1000),
    parameter logic [CW-1:0]   HANG_CYCLES    = CW'(64),
    parameter logic [31:0]     PASS_PC        = 32'h0000_0100,
    parameter logic [31:0]     FAIL_PC        = 32'h0000_0200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [31:0]   pc,
    input  logic [31:0]   inst,
    output logic          core_rst_n,
    output logic          done,
    output logic [2:0]    status,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] fetch_cnt,
    output logic [31:0]   last_inst
);

    typedef enum logic [2:0] {
        ST_HOLD, ST_RUN, ST_PASS, ST_FAIL, ST_HANG, ST_TOUT
    } state_t;

    localparam logic [CW-1:0] RST_LAST  = RST_CYCLES - CW'(1);
    localparam logic [CW-1:0] TOUT_LAST = TIMEOUT_CYCLES - CW'(1);

    state_t        state, state_next;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] stall_cnt, stall_next;
    logic [31:0]   pc_reg;
    logic          pc_valid;
    logic          fetch, repeat_fetch, hang_hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        fetch        = (state == ST_RUN) && ce;
        repeat_fetch = fetch && pc_valid && (pc == pc_reg);
        stall_next   = stall_cnt;
        if (fetch) stall_next = repeat_fetch ? sat_inc(stall_cnt) : '0;
        hang_hit     = repeat_fetch && (stall_next == HANG_CYCLES);

        state_next = state;
        case (state)
            ST_HOLD: if (hold_cnt == RST_LAST) state_next = ST_RUN;
            ST_RUN: begin
                if (fetch && pc == FAIL_PC)      state_next = ST_FAIL;
                else if (fetch && pc == PASS_PC) state_next = ST_PASS;
                else if (hang_hit)               state_next = ST_HANG;
                else if (cycle_cnt == TOUT_LAST) state_next = ST_TOUT;
            end
            default: state_next = state;
        endcase

        status = 3'd0;
        case (state)
            ST_PASS: status = 3'd1;
            ST_FAIL: status = 3'd2;
            ST_HANG: status = 3'd3;
            ST_TOUT: status = 3'd4;
            default: status = 3'd0;
        endcase
        done = (status != 3'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HOLD;
            core_rst_n <= 1'b0;
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            fetch_cnt  <= '0;
            stall_cnt  <= '0;
            last_inst  <= '0;
            pc_reg     <= '0;
            pc_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            core_rst_n <= (state_next != ST_HOLD);
            if (state == ST_HOLD) hold_cnt <= sat_inc(hold_cnt);
            // The cycle that ends the run is not counted, so a timeout freezes at TIMEOUT_CYCLES-1.
            if (state == ST_RUN && state_next == ST_RUN) cycle_cnt <= sat_inc(cycle_cnt);
            if (fetch) begin
                fetch_cnt <= sat_inc(fetch_cnt);
                last_inst <= inst;
                pc_reg    <= pc;
                pc_valid  <= 1'b1;
                stall_cnt <= stall_next;
            end
        end
    end

endmodule
